// File: rtl/spi_driver_simple_if.sv
// Display-side SPI bus bundle for spi_driver_simple.
// Signals:
//   miso          display -> driver, serial data (sampled on sck rise)
//   mosi          driver -> display, serial data
//   sck           SPI clock, idle low
//   cs            chip select, active low
//   dc            0 = command byte, 1 = data byte
//   reset_display display hardware reset, active low
//   LED           4-bit progress/status
// Modports: master (the driver), slave (the display side / bench).
interface spi_driver_simple_if;
    logic       miso;
    logic       mosi;
    logic       sck;
    logic       cs;
    logic       dc;
    logic       reset_display;
    logic [3:0] LED;

    modport master (
        input  miso,
        output mosi,
        output sck,
        output cs,
        output dc,
        output reset_display,
        output LED
    );

    modport slave (
        output miso,
        input  mosi,
        input  sck,
        input  cs,
        input  dc,
        input  reset_display,
        input  LED
    );
endinterface

// File: rtl/spi_driver_simple.sv
// Self-running SPI mode-0 master that brings up an SSD1306-class display:
// pulses the display reset low, waits, sends an 8-entry {dc, byte} init table
// MSB first, then idles in DONE until the next system reset.
// Ports:
//   CLK    system clock, rising edge
//   RESET  synchronous, active-high reset
//   bus    spi_driver_simple_if.master (miso in; mosi, sck, cs, dc,
//          reset_display, LED out)
// LED[0] reset pulse done, LED[1] transfer phase, LED[2] done,
// LED[3] sticky "some sampled miso bit was 1".
module spi_driver_simple #(
    parameter int unsigned CLK_DIV          = 4,
    parameter int unsigned RST_PULSE_CYCLES = 100,
    parameter int unsigned RST_WAIT_CYCLES  = 200
) (
    input  logic                CLK,
    input  logic                RESET,
    spi_driver_simple_if.master bus
);

    typedef enum logic [2:0] {
        StRstLow,
        StRstWait,
        StLoad,
        StShiftLo,
        StShiftHi,
        StGap,
        StDone
    } state_e;

    state_e      state_q, state_d;
    logic [31:0] cnt_q, cnt_d;
    logic [2:0]  idx_q, idx_d;
    logic [2:0]  bit_q, bit_d;
    logic [7:0]  tx_q, tx_d;
    logic [7:0]  rx_q, rx_d;
    logic        cs_q, cs_d;
    logic        sck_q, sck_d;
    logic        dc_q, dc_d;
    logic        rd_q, rd_d;
    logic [3:0]  led_q, led_d;
    logic        load_go;
    logic        sample;
    logic [8:0]  entry;

    // {dc, byte} init table.
    function automatic logic [8:0] init_entry(input logic [2:0] idx);
        logic [8:0] e;
        unique case (idx)
            3'd0: e = {1'b0, 8'hAE};
            3'd1: e = {1'b0, 8'hA8};
            3'd2: e = {1'b0, 8'h3F};
            3'd3: e = {1'b0, 8'h8D};
            3'd4: e = {1'b0, 8'h14};
            3'd5: e = {1'b0, 8'hAF};
            3'd6: e = {1'b1, 8'hFF};
            default: e = {1'b1, 8'h00};
        endcase
        return e;
    endfunction

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        bit_d   = bit_q;
        tx_d    = tx_q;
        rx_d    = rx_q;
        cs_d    = cs_q;
        sck_d   = sck_q;
        dc_d    = dc_q;
        rd_d    = rd_q;
        load_go = 1'b0;
        sample  = 1'b0;
        entry   = 9'd0;

        unique case (state_q)
            StRstLow: begin
                rd_d = 1'b0;
                if (cnt_q == RST_PULSE_CYCLES - 1) begin
                    state_d = StRstWait;
                    cnt_d   = '0;
                    rd_d    = 1'b1;
                end else begin
                    cnt_d = cnt_q + 32'd1;
                end
            end
            StRstWait: begin
                if (cnt_q == RST_WAIT_CYCLES - 1) begin
                    idx_d   = 3'd0;
                    load_go = 1'b1;
                end else begin
                    cnt_d = cnt_q + 32'd1;
                end
            end
            StLoad: begin
                state_d = StShiftLo;
                cnt_d   = '0;
            end
            StShiftLo: begin
                if (cnt_q == CLK_DIV - 1) begin
                    state_d = StShiftHi;
                    cnt_d   = '0;
                    sck_d   = 1'b1;
                    sample  = 1'b1;
                    rx_d    = {rx_q[6:0], bus.miso};
                end else begin
                    cnt_d = cnt_q + 32'd1;
                end
            end
            StShiftHi: begin
                if (cnt_q == CLK_DIV - 1) begin
                    cnt_d = '0;
                    sck_d = 1'b0;
                    if (bit_q != 3'd7) begin
                        // mosi is tx_q[7], so shifting presents the next bit
                        // while sck is low.
                        tx_d    = {tx_q[6:0], 1'b0};
                        bit_d   = bit_q + 3'd1;
                        state_d = StShiftLo;
                    end else begin
                        cs_d    = 1'b1;
                        state_d = StGap;
                    end
                end else begin
                    cnt_d = cnt_q + 32'd1;
                end
            end
            StGap: begin
                if (cnt_q == CLK_DIV - 1) begin
                    cnt_d = '0;
                    if (idx_q != 3'd7) begin
                        idx_d   = idx_q + 3'd1;
                        load_go = 1'b1;
                    end else begin
                        state_d = StDone;
                        tx_d    = 8'h00;
                    end
                end else begin
                    cnt_d = cnt_q + 32'd1;
                end
            end
            StDone: begin
                cs_d  = 1'b1;
                sck_d = 1'b0;
                tx_d  = 8'h00;
                rd_d  = 1'b1;
            end
            default: begin
                state_d = StRstLow;
                cnt_d   = '0;
            end
        endcase

        // Outputs for LOAD are registered on entry so cs/dc/mosi are valid
        // during the LOAD cycle itself.
        if (load_go) begin
            entry   = init_entry(idx_d);
            state_d = StLoad;
            cnt_d   = '0;
            bit_d   = 3'd0;
            cs_d    = 1'b0;
            sck_d   = 1'b0;
            dc_d    = entry[8];
            tx_d    = entry[7:0];
        end

        led_d[0] = led_q[0] | (state_q == StRstLow && state_d == StRstWait);
        led_d[1] = (state_d == StLoad) || (state_d == StShiftLo) ||
                   (state_d == StShiftHi) || (state_d == StGap);
        led_d[2] = (state_d == StDone);
        // The received byte has no other consumer; it only feeds the sticky flag.
        led_d[3] = led_q[3] | (|rx_q) | (sample & bus.miso);
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q <= StRstLow;
            cnt_q   <= '0;
            idx_q   <= '0;
            bit_q   <= '0;
            tx_q    <= '0;
            rx_q    <= '0;
            cs_q    <= 1'b1;
            sck_q   <= 1'b0;
            dc_q    <= 1'b0;
            rd_q    <= 1'b0;
            led_q   <= 4'b0000;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            bit_q   <= bit_d;
            tx_q    <= tx_d;
            rx_q    <= rx_d;
            cs_q    <= cs_d;
            sck_q   <= sck_d;
            dc_q    <= dc_d;
            rd_q    <= rd_d;
            led_q   <= led_d;
        end
    end

    assign bus.mosi          = tx_q[7];
    assign bus.sck           = sck_q;
    assign bus.cs            = cs_q;
    assign bus.dc            = dc_q;
    assign bus.reset_display = rd_q;
    assign bus.LED           = led_q;

endmodule

// File: tb/tb_spi_driver_simple.sv
// Bench for spi_driver_simple: checkpoint table at fixed cycle offsets after
// reset release, plus a bus monitor that decodes each cs-low window and
// compares it against an expected-byte queue filled when reset is released.
module tb_spi_driver_simple;

    logic clk = 1'b0;
    logic rst = 1'b1;

    spi_driver_simple_if bus ();

    spi_driver_simple #(
        .CLK_DIV          (4),
        .RST_PULSE_CYCLES (100),
        .RST_WAIT_CYCLES  (200)
    ) dut (
        .CLK   (clk),
        .RESET (rst),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        int         k;
        logic       miso;
        logic       cs;
        logic       sck;
        logic       mosi;
        logic       dc;
        logic       rd;
        logic [3:0] led;
        bit         md;
    } vec_t;

    vec_t       vecs[$];
    logic [8:0] sb[$];
    logic [8:0] init_tbl[8] = '{9'h0AE, 9'h0A8, 9'h03F, 9'h08D,
                                9'h014, 9'h0AF, 9'h1FF, 9'h100};
    int total = 0;
    int bad   = 0;
    int kcur  = 0;
    int glitches = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic adv_to(input int k);
        while (kcur < k) begin
            @(posedge clk);
            #1;
            kcur++;
        end
    endtask

    task automatic push_seq();
        sb.delete();
        for (int i = 0; i < 8; i++) sb.push_back(init_tbl[i]);
    endtask

    task automatic release_reset();
        rst = 1'b1;
        repeat (6) @(posedge clk);
        #1;
        rst  = 1'b0;
        kcur = 0;
        push_seq();
    endtask

    task automatic run_table();
        foreach (vecs[i]) begin
            adv_to(vecs[i].k);
            bus.miso = vecs[i].miso;
            chk($sformatf("cs@%0d", vecs[i].k), 32'(bus.cs), 32'(vecs[i].cs));
            chk($sformatf("sck@%0d", vecs[i].k), 32'(bus.sck), 32'(vecs[i].sck));
            chk($sformatf("rd@%0d", vecs[i].k), 32'(bus.reset_display), 32'(vecs[i].rd));
            chk($sformatf("led@%0d", vecs[i].k), 32'(bus.LED), 32'(vecs[i].led));
            if (vecs[i].md) begin
                chk($sformatf("mosi@%0d", vecs[i].k), 32'(bus.mosi), 32'(vecs[i].mosi));
                chk($sformatf("dc@%0d", vecs[i].k), 32'(bus.dc), 32'(vecs[i].dc));
            end
        end
    endtask

    // Bus monitor on the falling edge, away from DUT updates.
    logic       sck_prev = 1'b0;
    logic       cs_prev  = 1'b1;
    logic       mosi_prev = 1'b0;
    logic       aborted  = 1'b1;
    logic       dc_first = 1'b0;
    logic       dc_bad   = 1'b0;
    logic [7:0] rx_byte  = 8'h00;
    int         nbits    = 0;

    always @(negedge clk) begin
        logic [8:0] exp;
        if (rst) begin
            aborted = 1'b1;
            nbits   = 0;
        end else begin
            if (cs_prev && !bus.cs) begin
                aborted  = 1'b0;
                nbits    = 0;
                dc_bad   = 1'b0;
                dc_first = bus.dc;
            end
            if (!bus.cs && bus.sck && !sck_prev) begin
                rx_byte = {rx_byte[6:0], bus.mosi};
                if (bus.dc !== dc_first) dc_bad = 1'b1;
                nbits++;
            end
            if (bus.sck && sck_prev && (bus.mosi !== mosi_prev)) glitches++;
            if (!cs_prev && bus.cs && !aborted) begin
                if (sb.size() == 0) begin
                    chk("sb_extra_byte", 32'(rx_byte), 32'hFFFF_FFFF);
                end else begin
                    exp = sb.pop_front();
                    chk("sb_byte", 32'(rx_byte), 32'(exp[7:0]));
                    chk("sb_dc", 32'(dc_first), 32'(exp[8]));
                    chk("sb_edges", 32'(nbits), 32'd8);
                    chk("sb_dc_stable", 32'(dc_bad), 32'd0);
                end
            end
        end
        sck_prev  = bus.sck;
        cs_prev   = bus.cs;
        mosi_prev = bus.mosi;
    end

    initial begin
        //                k    miso  cs    sck   mosi  dc    rd    led      md
        vecs.push_back('{0,   1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'b0000, 1'b1});
        vecs.push_back('{99,  1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'b0000, 1'b1});
        vecs.push_back('{100, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 4'b0001, 1'b1});
        vecs.push_back('{299, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 4'b0001, 1'b1});
        vecs.push_back('{300, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 4'b0011, 1'b1});
        vecs.push_back('{304, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 4'b0011, 1'b1});
        vecs.push_back('{305, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 4'b0011, 1'b1});
        vecs.push_back('{308, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 4'b0011, 1'b1});
        vecs.push_back('{309, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 4'b0011, 1'b1});
        vecs.push_back('{364, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 4'b0011, 1'b1});
        vecs.push_back('{365, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 4'b0011, 1'b0});
        vecs.push_back('{368, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 4'b0011, 1'b0});
        vecs.push_back('{369, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 4'b0011, 1'b1});
        vecs.push_back('{714, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 4'b0011, 1'b1});
        vecs.push_back('{851, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 4'b0011, 1'b0});
        vecs.push_back('{852, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 4'b0101, 1'b1});
        vecs.push_back('{900, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 4'b0101, 1'b1});

        bus.miso = 1'b0;

        // Full sequence with miso low.
        release_reset();
        run_table();
        chk("sb_drained_run1", 32'(sb.size()), 32'd0);

        // miso high during byte 2, then a one-cycle reset in the middle of byte 3.
        release_reset();
        adv_to(440);
        bus.miso = 1'b1;
        adv_to(442);
        chk("led_before_sample", 32'(bus.LED), 32'b0011);
        adv_to(443);
        chk("led3_set", 32'(bus.LED), 32'b1011);
        adv_to(500);
        bus.miso = 1'b0;
        adv_to(537);
        chk("led3_sticky", 32'(bus.LED), 32'b1011);
        chk("abort_cs_low", 32'(bus.cs), 32'd0);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst  = 1'b0;
        kcur = 0;
        push_seq();
        chk("abort_led_cleared", 32'(bus.LED), 32'd0);
        run_table();
        chk("sb_drained_replay", 32'(sb.size()), 32'd0);
        chk("mosi_stable_sck_high", 32'(glitches), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
